// File: rtl/csr_file.sv
// csr_file: LoongArch control/status register file answering WB-stage reads and
// masked writes, committing exception/ertn side effects, with a down-counting timer.
module csr_file #(
  parameter logic [31:0] COREID = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        csr_re,
  input  logic [13:0] csr_num,
  output logic [31:0] csr_rvalue,
  input  logic        csr_we,
  input  logic [31:0] csr_wmask,
  input  logic [31:0] csr_wvalue,
  input  logic        wb_ex,
  input  logic [31:0] wb_pc,
  input  logic [5:0]  wb_ecode,
  input  logic [8:0]  wb_esubcode,
  input  logic        ertn_flush,
  input  logic [7:0]  hw_int_in,
  input  logic        ipi_int_in,
  output logic [31:0] ex_entry,
  output logic [31:0] ertn_entry,
  output logic        has_int
);

  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ECFG   = 14'h004;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_EENTRY = 14'h00c;
  localparam logic [13:0] CSR_SAVE0  = 14'h030;
  localparam logic [13:0] CSR_TID    = 14'h040;
  localparam logic [13:0] CSR_TCFG   = 14'h041;
  localparam logic [13:0] CSR_TVAL   = 14'h042;
  localparam logic [13:0] CSR_TICLR  = 14'h044;

  // Interrupt bit 10 does not exist; it is kept zero in both LIE and the enable mask.
  localparam logic [12:0] LIE_MASK  = 13'h1BFF;
  localparam logic [31:0] TVAL_IDLE = 32'hFFFF_FFFF;

  logic [8:0]  crmd_reg;
  logic [2:0]  prmd_reg;
  logic [12:0] ecfg_reg;
  logic [12:0] estat_is_reg;
  logic [5:0]  estat_ecode_reg;
  logic [8:0]  estat_esub_reg;
  logic [31:0] era_reg;
  logic [25:0] eentry_reg;
  logic [31:0] save_reg [4];
  logic [31:0] tid_reg;
  logic [31:0] tcfg_reg;
  logic [31:0] tval_reg;

  logic        wr_en;
  logic [31:0] wr_set;
  logic [31:0] wr_keep;
  logic        wr_crmd, wr_prmd, wr_ecfg, wr_estat, wr_era, wr_eentry;
  logic        wr_tid, wr_tcfg, wr_ticlr;
  logic [31:0] tcfg_next;
  logic        timer_load, timer_run, timer_fire, ticlr_clr;

  // Exception and ertn commits both suppress the ordinary CSR write.
  assign wr_en   = csr_we & ~wb_ex & ~ertn_flush;
  assign wr_set  = csr_wvalue & csr_wmask;
  assign wr_keep = ~csr_wmask;

  assign wr_crmd   = wr_en && (csr_num == CSR_CRMD);
  assign wr_prmd   = wr_en && (csr_num == CSR_PRMD);
  assign wr_ecfg   = wr_en && (csr_num == CSR_ECFG);
  assign wr_estat  = wr_en && (csr_num == CSR_ESTAT);
  assign wr_era    = wr_en && (csr_num == CSR_ERA);
  assign wr_eentry = wr_en && (csr_num == CSR_EENTRY);
  assign wr_tid    = wr_en && (csr_num == CSR_TID);
  assign wr_tcfg   = wr_en && (csr_num == CSR_TCFG);
  assign wr_ticlr  = wr_en && (csr_num == CSR_TICLR);

  assign tcfg_next  = (tcfg_reg & wr_keep) | wr_set;
  assign timer_load = wr_tcfg & tcfg_next[0];
  assign timer_run  = ~timer_load & tcfg_reg[0] & (tval_reg != TVAL_IDLE);
  assign timer_fire = timer_run & (tval_reg == 32'd0);
  assign ticlr_clr  = wr_ticlr & wr_set[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      crmd_reg <= 9'h008;
    end else if (wb_ex) begin
      crmd_reg[2:0] <= 3'b000;
    end else if (ertn_flush) begin
      crmd_reg[2:0] <= prmd_reg;
    end else if (wr_crmd) begin
      crmd_reg <= (crmd_reg & wr_keep[8:0]) | wr_set[8:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prmd_reg <= 3'b000;
    end else if (wb_ex) begin
      prmd_reg <= crmd_reg[2:0];
    end else if (wr_prmd) begin
      prmd_reg <= (prmd_reg & wr_keep[2:0]) | wr_set[2:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ecfg_reg <= 13'h0;
    end else if (wr_ecfg) begin
      ecfg_reg <= ((ecfg_reg & wr_keep[12:0]) | wr_set[12:0]) & LIE_MASK;
    end
  end

  // Interrupt status is resampled every cycle; the timer bit sets over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      estat_is_reg    <= 13'h0;
      estat_ecode_reg <= 6'h0;
      estat_esub_reg  <= 9'h0;
    end else begin
      if (wr_estat) begin
        estat_is_reg[1:0] <= (estat_is_reg[1:0] & wr_keep[1:0]) | wr_set[1:0];
      end
      estat_is_reg[9:2] <= hw_int_in;
      estat_is_reg[10]  <= 1'b0;
      estat_is_reg[11]  <= timer_fire | (estat_is_reg[11] & ~ticlr_clr);
      estat_is_reg[12]  <= ipi_int_in;
      if (wb_ex) begin
        estat_ecode_reg <= wb_ecode;
        estat_esub_reg  <= wb_esubcode;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      era_reg <= 32'h0;
    end else if (wb_ex) begin
      era_reg <= wb_pc;
    end else if (wr_era) begin
      era_reg <= (era_reg & wr_keep) | wr_set;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      eentry_reg <= 26'h0;
      tid_reg    <= COREID;
      tcfg_reg   <= 32'h0;
    end else begin
      if (wr_eentry) begin
        eentry_reg <= (eentry_reg & wr_keep[31:6]) | wr_set[31:6];
      end
      if (wr_tid) begin
        tid_reg <= (tid_reg & wr_keep) | wr_set;
      end
      if (wr_tcfg) begin
        tcfg_reg <= tcfg_next;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_save
      logic wr_save;
      assign wr_save = wr_en && (csr_num == (CSR_SAVE0 + 14'(gi)));
      always_ff @(posedge clk) begin
        if (reset) begin
          save_reg[gi] <= 32'h0;
        end else if (wr_save) begin
          save_reg[gi] <= (save_reg[gi] & wr_keep) | wr_set;
        end
      end
    end
  endgenerate

  // TVAL == all-ones marks a stopped one-shot timer; it only restarts on a TCFG write.
  always_ff @(posedge clk) begin
    if (reset) begin
      tval_reg <= TVAL_IDLE;
    end else if (timer_load) begin
      tval_reg <= {tcfg_next[31:2], 2'b00};
    end else if (timer_fire) begin
      tval_reg <= tcfg_reg[1] ? {tcfg_reg[31:2], 2'b00} : TVAL_IDLE;
    end else if (timer_run) begin
      tval_reg <= tval_reg - 32'd1;
    end
  end

  always_comb begin
    csr_rvalue = 32'h0;
    if (csr_re) begin
      case (csr_num)
        CSR_CRMD:       csr_rvalue = {23'h0, crmd_reg};
        CSR_PRMD:       csr_rvalue = {29'h0, prmd_reg};
        CSR_ECFG:       csr_rvalue = {19'h0, ecfg_reg};
        CSR_ESTAT:      csr_rvalue = {1'b0, estat_esub_reg, estat_ecode_reg, 3'b000, estat_is_reg};
        CSR_ERA:        csr_rvalue = era_reg;
        CSR_EENTRY:     csr_rvalue = {eentry_reg, 6'h0};
        CSR_SAVE0:      csr_rvalue = save_reg[0];
        CSR_SAVE0 + 1:  csr_rvalue = save_reg[1];
        CSR_SAVE0 + 2:  csr_rvalue = save_reg[2];
        CSR_SAVE0 + 3:  csr_rvalue = save_reg[3];
        CSR_TID:        csr_rvalue = tid_reg;
        CSR_TCFG:       csr_rvalue = tcfg_reg;
        CSR_TVAL:       csr_rvalue = tval_reg;
        default:        csr_rvalue = 32'h0;
      endcase
    end
  end

  assign ex_entry   = {eentry_reg, 6'h0};
  assign ertn_entry = era_reg;
  assign has_int    = crmd_reg[2] & (|(estat_is_reg & ecfg_reg & LIE_MASK));

endmodule

// File: tb/tb_csr_file.sv
// Directed self-checking bench for csr_file: register map, exception/ertn,
// interrupt sampling and the one-shot / periodic timer.
module tb_csr_file;

  localparam logic [31:0] COREID = 32'h0000_0005;

  localparam logic [13:0] A_CRMD   = 14'h000;
  localparam logic [13:0] A_PRMD   = 14'h001;
  localparam logic [13:0] A_ECFG   = 14'h004;
  localparam logic [13:0] A_ESTAT  = 14'h005;
  localparam logic [13:0] A_ERA    = 14'h006;
  localparam logic [13:0] A_EENTRY = 14'h00c;
  localparam logic [13:0] A_SAVE0  = 14'h030;
  localparam logic [13:0] A_SAVE1  = 14'h031;
  localparam logic [13:0] A_SAVE2  = 14'h032;
  localparam logic [13:0] A_TID    = 14'h040;
  localparam logic [13:0] A_TCFG   = 14'h041;
  localparam logic [13:0] A_TVAL   = 14'h042;
  localparam logic [13:0] A_TICLR  = 14'h044;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        csr_re = 1'b1;
  logic [13:0] csr_num = 14'h0;
  logic [31:0] csr_rvalue;
  logic        csr_we = 1'b0;
  logic [31:0] csr_wmask = 32'h0;
  logic [31:0] csr_wvalue = 32'h0;
  logic        wb_ex = 1'b0;
  logic [31:0] wb_pc = 32'h0;
  logic [5:0]  wb_ecode = 6'h0;
  logic [8:0]  wb_esubcode = 9'h0;
  logic        ertn_flush = 1'b0;
  logic [7:0]  hw_int_in = 8'h0;
  logic        ipi_int_in = 1'b0;
  logic [31:0] ex_entry;
  logic [31:0] ertn_entry;
  logic        has_int;

  int checks = 0;
  int errors = 0;

  csr_file #(.COREID(COREID)) dut (
    .clk(clk), .reset(reset), .csr_re(csr_re), .csr_num(csr_num),
    .csr_rvalue(csr_rvalue), .csr_we(csr_we), .csr_wmask(csr_wmask),
    .csr_wvalue(csr_wvalue), .wb_ex(wb_ex), .wb_pc(wb_pc),
    .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .ertn_flush(ertn_flush),
    .hw_int_in(hw_int_in), .ipi_int_in(ipi_int_in), .ex_entry(ex_entry),
    .ertn_entry(ertn_entry), .has_int(has_int)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [13:0] a, output logic [31:0] d);
    csr_num = a;
    #1;
    d = csr_rvalue;
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] v, input logic [31:0] m);
    csr_num = a; csr_wvalue = v; csr_wmask = m; csr_we = 1'b1;
    tick();
    csr_we = 1'b0; csr_wmask = 32'h0;
    $display("wr   csr %h value %h mask %h", a, v, m);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rd(A_CRMD, d);
    checks++; if (d !== 32'h8) begin errors++; $display("FAIL reset_crmd got %h exp %h", d, 32'h8); end
    rd(A_TID, d);
    checks++; if (d !== COREID) begin errors++; $display("FAIL reset_tid got %h exp %h", d, COREID); end
    rd(A_TVAL, d);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_tval got %h exp ffffffff", d); end
    tick();
    rd(A_ESTAT, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_estat got %h exp 0", d); end
    checks++; if (ex_entry !== 32'h0) begin errors++; $display("FAIL reset_ex_entry got %h exp 0", ex_entry); end
    checks++; if (has_int !== 1'b0) begin errors++; $display("FAIL reset_has_int got %b exp 0", has_int); end
    rd(14'h007, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped_read got %h exp 0", d); end
    $display("test_reset done");
  endtask

  task automatic test_masked_write();
    logic [31:0] d;
    wr(A_SAVE0, 32'h1234_5678, 32'hFFFF_FFFF);
    wr(A_SAVE0, 32'hFFFF_FFFF, 32'h0000_00FF);
    rd(A_SAVE0, d);
    checks++; if (d !== 32'h1234_56FF) begin errors++; $display("FAIL save0_masked got %h exp 123456ff", d); end
    wr(A_EENTRY, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rd(A_EENTRY, d);
    checks++; if (d !== 32'hFFFF_FFC0) begin errors++; $display("FAIL eentry_read got %h exp ffffffc0", d); end
    checks++; if (ex_entry !== 32'hFFFF_FFC0) begin errors++; $display("FAIL ex_entry got %h exp ffffffc0", ex_entry); end
    wr(A_ECFG, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rd(A_ECFG, d);
    checks++; if (d !== 32'h0000_1BFF) begin errors++; $display("FAIL ecfg_bits got %h exp 00001bff", d); end
    wr(A_ECFG, 32'h0, 32'hFFFF_FFFF);
    wr(A_ESTAT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rd(A_ESTAT, d);
    checks++; if (d !== 32'h0000_0003) begin errors++; $display("FAIL estat_sw_bits got %h exp 00000003", d); end
    wr(A_ESTAT, 32'h0, 32'hFFFF_FFFF);
    wr(A_TICLR, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rd(A_TICLR, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL ticlr_read got %h exp 0", d); end
    $display("test_masked_write done");
  endtask

  task automatic test_no_forward();
    logic [31:0] d;
    csr_num = A_SAVE2; csr_wvalue = 32'hDEAD_BEEF; csr_wmask = 32'hFFFF_FFFF; csr_we = 1'b1;
    #1;
    d = csr_rvalue;
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL no_forward got %h exp 0", d); end
    tick();
    csr_we = 1'b0; csr_wmask = 32'h0;
    rd(A_SAVE2, d);
    checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL write_visible got %h exp deadbeef", d); end
    $display("test_no_forward done");
  endtask

  task automatic test_exception();
    logic [31:0] d;
    wr(A_CRMD, 32'h7, 32'hFFFF_FFFF);
    wr(A_SAVE1, 32'hAAAA_5555, 32'hFFFF_FFFF);
    wb_ex = 1'b1; wb_pc = 32'h1C00_0100; wb_ecode = 6'hB; wb_esubcode = 9'h3;
    csr_num = A_SAVE1; csr_wvalue = 32'h0; csr_wmask = 32'hFFFF_FFFF; csr_we = 1'b1;
    tick();
    wb_ex = 1'b0; csr_we = 1'b0; csr_wmask = 32'h0;
    $display("ex   pc %h ecode %h", wb_pc, wb_ecode);
    rd(A_ERA, d);
    checks++; if (d !== 32'h1C00_0100) begin errors++; $display("FAIL ex_era got %h exp 1c000100", d); end
    rd(A_ESTAT, d);
    checks++; if (d[21:16] !== 6'hB) begin errors++; $display("FAIL ex_ecode got %h exp 0b", d[21:16]); end
    checks++; if (d[30:22] !== 9'h3) begin errors++; $display("FAIL ex_esubcode got %h exp 003", d[30:22]); end
    rd(A_PRMD, d);
    checks++; if (d !== 32'h7) begin errors++; $display("FAIL ex_prmd got %h exp 7", d); end
    tick();
    rd(A_CRMD, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL ex_crmd got %h exp 0", d); end
    rd(A_SAVE1, d);
    checks++; if (d !== 32'hAAAA_5555) begin errors++; $display("FAIL ex_save1_kept got %h exp aaaa5555", d); end
    ertn_flush = 1'b1;
    tick();
    ertn_flush = 1'b0;
    $display("ertn");
    rd(A_CRMD, d);
    checks++; if (d !== 32'h7) begin errors++; $display("FAIL ertn_crmd got %h exp 7", d); end
    checks++; if (ertn_entry !== 32'h1C00_0100) begin errors++; $display("FAIL ertn_entry got %h exp 1c000100", ertn_entry); end
    $display("test_exception done");
  endtask

  task automatic test_ex_and_ertn();
    logic [31:0] d;
    wb_ex = 1'b1; ertn_flush = 1'b1; wb_pc = 32'h1C00_0200; wb_ecode = 6'h8; wb_esubcode = 9'h0;
    tick();
    wb_ex = 1'b0; ertn_flush = 1'b0;
    $display("ex+ertn pc %h", wb_pc);
    rd(A_CRMD, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL both_crmd got %h exp 0", d); end
    rd(A_ERA, d);
    checks++; if (d !== 32'h1C00_0200) begin errors++; $display("FAIL both_era got %h exp 1c000200", d); end
    rd(A_PRMD, d);
    checks++; if (d !== 32'h7) begin errors++; $display("FAIL both_prmd got %h exp 7", d); end
    tick();
    rd(A_ESTAT, d);
    checks++; if (d[21:16] !== 6'h8) begin errors++; $display("FAIL both_ecode got %h exp 08", d[21:16]); end
    $display("test_ex_and_ertn done");
  endtask

  task automatic test_irq_sample();
    logic [31:0] d;
    hw_int_in = 8'hA5; ipi_int_in = 1'b1;
    rd(A_ESTAT, d);
    checks++; if (d[12:0] !== 13'h0) begin errors++; $display("FAIL irq_latency got %h exp 0000", d[12:0]); end
    tick();
    rd(A_ESTAT, d);
    checks++; if (d[12:0] !== 13'h1294) begin errors++; $display("FAIL irq_sampled got %h exp 1294", d[12:0]); end
    hw_int_in = 8'h0; ipi_int_in = 1'b0;
    tick();
    rd(A_ESTAT, d);
    checks++; if (d[12:0] !== 13'h0) begin errors++; $display("FAIL irq_cleared got %h exp 0000", d[12:0]); end
    $display("test_irq_sample done");
  endtask

  task automatic test_oneshot_timer();
    logic [31:0] d;
    wr(A_TCFG, 32'h9, 32'hFFFF_FFFF);
    for (int e = 8; e >= 0; e--) begin
      rd(A_TVAL, d);
      checks++; if (d !== 32'(e)) begin errors++; $display("FAIL oneshot_tval got %h exp %h", d, 32'(e)); end
      rd(A_ESTAT, d);
      checks++; if (d[11] !== 1'b0) begin errors++; $display("FAIL oneshot_is11_early got %b exp 0", d[11]); end
      $display("tval %0d", e);
      tick();
    end
    rd(A_TVAL, d);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL oneshot_stop got %h exp ffffffff", d); end
    rd(A_ESTAT, d);
    checks++; if (d[11] !== 1'b1) begin errors++; $display("FAIL oneshot_is11 got %b exp 1", d[11]); end
    tick();
    rd(A_TVAL, d);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL oneshot_stays got %h exp ffffffff", d); end
    wr(A_ECFG, 32'h800, 32'hFFFF_FFFF);
    wr(A_CRMD, 32'h4, 32'h4);
    checks++; if (has_int !== 1'b1) begin errors++; $display("FAIL has_int_set got %b exp 1", has_int); end
    wr(A_TICLR, 32'h1, 32'h1);
    rd(A_ESTAT, d);
    checks++; if (d[11] !== 1'b0) begin errors++; $display("FAIL ticlr_clear got %b exp 0", d[11]); end
    checks++; if (has_int !== 1'b0) begin errors++; $display("FAIL has_int_clear got %b exp 0", has_int); end
    $display("test_oneshot_timer done");
  endtask

  task automatic test_periodic_timer();
    logic [31:0] d;
    wr(A_TCFG, 32'hB, 32'hFFFF_FFFF);
    rd(A_TVAL, d);
    checks++; if (d !== 32'h8) begin errors++; $display("FAIL periodic_load got %h exp 8", d); end
    repeat (8) tick();
    rd(A_TVAL, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL periodic_zero got %h exp 0", d); end
    wr(A_TICLR, 32'h1, 32'h1);
    rd(A_ESTAT, d);
    checks++; if (d[11] !== 1'b1) begin errors++; $display("FAIL set_beats_clear got %b exp 1", d[11]); end
    rd(A_TVAL, d);
    checks++; if (d !== 32'h8) begin errors++; $display("FAIL periodic_reload got %h exp 8", d); end
    checks++; if (has_int !== 1'b1) begin errors++; $display("FAIL periodic_has_int got %b exp 1", has_int); end
    tick();
    rd(A_TVAL, d);
    checks++; if (d !== 32'h7) begin errors++; $display("FAIL periodic_count got %h exp 7", d); end
    wr(A_TCFG, 32'h0, 32'hFFFF_FFFF);
    rd(A_TVAL, d);
    checks++; if (d !== 32'h6) begin errors++; $display("FAIL disable_last_count got %h exp 6", d); end
    tick();
    rd(A_TVAL, d);
    checks++; if (d !== 32'h6) begin errors++; $display("FAIL disable_hold got %h exp 6", d); end
    $display("test_periodic_timer done");
  endtask

  task automatic test_reset_priority();
    logic [31:0] d;
    reset = 1'b1; wb_ex = 1'b1; wb_pc = 32'h1234_0000;
    csr_num = A_SAVE0; csr_wvalue = 32'h5555_5555; csr_wmask = 32'hFFFF_FFFF; csr_we = 1'b1;
    tick();
    reset = 1'b0; wb_ex = 1'b0; csr_we = 1'b0; csr_wmask = 32'h0;
    $display("reset with ex and write");
    rd(A_CRMD, d);
    checks++; if (d !== 32'h8) begin errors++; $display("FAIL rst_prio_crmd got %h exp 8", d); end
    rd(A_SAVE0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_prio_save0 got %h exp 0", d); end
    rd(A_ERA, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_prio_era got %h exp 0", d); end
    rd(A_TVAL, d);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_prio_tval got %h exp ffffffff", d); end
    $display("test_reset_priority done");
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_masked_write();
    test_no_forward();
    test_exception();
    test_ex_and_ertn();
    test_irq_sample();
    test_oneshot_timer();
    test_periodic_timer();
    test_reset_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
